// File: rtl/add3_sched.sv
// Round-robin scheduler sharing one external three-input adder among N_REQ requesters.
// Response 2*LATENCY+1 edges after accept, one accept per cycle, no response backpressure.
module add3_sched #(
  parameter int N_REQ   = 4,
  parameter int LATENCY = 3,
  parameter int WIDTH   = 32
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic [N_REQ-1:0]                   i_req_valid,
  output logic [N_REQ-1:0]                   o_req_ready,
  input  logic [N_REQ*WIDTH-1:0]             i_req_a,
  input  logic [N_REQ*WIDTH-1:0]             i_req_b,
  input  logic [N_REQ*WIDTH-1:0]             i_req_c,
  output logic [WIDTH-1:0]                   o_add_a,
  output logic [WIDTH-1:0]                   o_add_b,
  output logic [WIDTH-1:0]                   o_add_c,
  input  logic [WIDTH-1:0]                   i_add_q,
  output logic                               o_rsp_valid,
  output logic [$clog2(N_REQ)-1:0]           o_rsp_id,
  output logic [WIDTH-1:0]                   o_rsp_q,
  output logic [$clog2(2*LATENCY+2)-1:0]     o_inflight
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int IW1   = ID_W + 1;
  localparam int DEPTH = 2 * LATENCY;
  localparam int CNT_W = $clog2(2 * LATENCY + 2);

  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
  } tag_t;

  logic [ID_W-1:0]          ptr_q, ptr_d;
  logic [WIDTH-1:0]         add_a_q, add_a_d;
  logic [WIDTH-1:0]         add_b_q, add_b_d;
  logic [WIDTH-1:0]         add_c_q, add_c_d;
  tag_t                     acc_q, acc_d;
  tag_t [DEPTH-1:0]         tag_q, tag_d;
  logic                     rsp_vld_q, rsp_vld_d;
  logic [ID_W-1:0]          rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0]         rsp_q_q, rsp_q_d;
  logic [CNT_W-1:0]         inflight_q, inflight_d;

  logic                     gnt_vld;
  logic [ID_W-1:0]          gnt_idx;
  logic [IW1-1:0]           scan_idx;
  logic [WIDTH-1:0]         sel_a, sel_b, sel_c;
  logic                     rsp_fire;

  // Scan upward from the pointer with wrap; first valid requester wins.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    scan_idx = '0;
    for (int off = 0; off < N_REQ; off++) begin
      scan_idx = {1'b0, ptr_q} + IW1'(off);
      if (scan_idx >= IW1'(N_REQ)) begin
        scan_idx = scan_idx - IW1'(N_REQ);
      end
      if (!gnt_vld && i_req_valid[scan_idx[ID_W-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = scan_idx[ID_W-1:0];
      end
    end
    if (i_rst) begin
      gnt_vld = 1'b0;
    end
  end

  assign o_req_ready = gnt_vld ? (N_REQ'(1) << gnt_idx) : '0;

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    sel_c = '0;
    for (int k = 0; k < N_REQ; k++) begin
      sel_a = sel_a | ({WIDTH{o_req_ready[k]}} & i_req_a[k*WIDTH +: WIDTH]);
      sel_b = sel_b | ({WIDTH{o_req_ready[k]}} & i_req_b[k*WIDTH +: WIDTH]);
      sel_c = sel_c | ({WIDTH{o_req_ready[k]}} & i_req_c[k*WIDTH +: WIDTH]);
    end
  end

  assign rsp_fire = tag_q[DEPTH-1].vld;

  always_comb begin
    ptr_d      = ptr_q;
    add_a_d    = add_a_q;
    add_b_d    = add_b_q;
    add_c_d    = add_c_q;
    acc_d      = '0;
    tag_d      = {tag_q[DEPTH-2:0], acc_q};
    rsp_vld_d  = rsp_fire;
    rsp_id_d   = rsp_id_q;
    rsp_q_d    = rsp_q_q;
    inflight_d = inflight_q;

    if (gnt_vld) begin
      ptr_d     = (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
      add_a_d   = sel_a;
      add_b_d   = sel_b;
      add_c_d   = sel_c;
      acc_d.vld = 1'b1;
      acc_d.id  = gnt_idx;
    end

    // The operand register is stage zero, so the tag trails it by one slot.
    if (rsp_fire) begin
      rsp_id_d = tag_q[DEPTH-1].id;
      rsp_q_d  = i_add_q;
    end

    case ({gnt_vld, rsp_fire})
      2'b10:   inflight_d = inflight_q + CNT_W'(1);
      2'b01:   inflight_d = inflight_q - CNT_W'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ptr_q      <= '0;
      add_a_q    <= '0;
      add_b_q    <= '0;
      add_c_q    <= '0;
      acc_q      <= '0;
      tag_q      <= '0;
      rsp_vld_q  <= 1'b0;
      rsp_id_q   <= '0;
      rsp_q_q    <= '0;
      inflight_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      add_a_q    <= add_a_d;
      add_b_q    <= add_b_d;
      add_c_q    <= add_c_d;
      acc_q      <= acc_d;
      tag_q      <= tag_d;
      rsp_vld_q  <= rsp_vld_d;
      rsp_id_q   <= rsp_id_d;
      rsp_q_q    <= rsp_q_d;
      inflight_q <= inflight_d;
    end
  end

  assign o_add_a     = add_a_q;
  assign o_add_b     = add_b_q;
  assign o_add_c     = add_c_q;
  assign o_rsp_valid = rsp_vld_q;
  assign o_rsp_id    = rsp_id_q;
  assign o_rsp_q     = rsp_q_q;
  assign o_inflight  = inflight_q;

endmodule

// File: tb/tb_add3_sched.sv
// Directed bench for add3_sched with a behavioural 2*LATENCY-deep shared adder.
module tb_add3_sched;

  localparam int N   = 4;
  localparam int LAT = 3;
  localparam int W   = 32;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*W-1:0]  req_a, req_b, req_c;
  logic [W-1:0]    add_a, add_b, add_c;
  logic [W-1:0]    add_q;
  logic            rsp_valid;
  logic [1:0]      rsp_id;
  logic [W-1:0]    rsp_q;
  logic [2:0]      inflight;

  add3_sched #(.N_REQ(N), .LATENCY(LAT), .WIDTH(W)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_a     (req_a),
    .i_req_b     (req_b),
    .i_req_c     (req_c),
    .o_add_a     (add_a),
    .o_add_b     (add_b),
    .o_add_c     (add_c),
    .i_add_q     (add_q),
    .o_rsp_valid (rsp_valid),
    .o_rsp_id    (rsp_id),
    .o_rsp_q     (rsp_q),
    .o_inflight  (inflight)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared adder: result appears 2*LAT edges after operands are presented.
  logic [W-1:0] pipe [0:2*LAT-1];
  always @(posedge clk) begin
    pipe[0] <= add_a + add_b + add_c;
    for (int i = 1; i < 2*LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign add_q = pipe[2*LAT-1];

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int pk     = 0;
  int         rid_q [$];
  logic [W-1:0] rq_q [$];
  int         rcyc_q [$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (rsp_valid) begin
      rid_q.push_back(int'(rsp_id));
      rq_q.push_back(rsp_q);
      rcyc_q.push_back(cyc);
    end
    if (int'(inflight) > pk) pk = int'(inflight);
  endtask

  task automatic clear_rsp();
    rid_q.delete();
    rq_q.delete();
    rcyc_q.delete();
  endtask

  task automatic set_ops(input int k, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] c);
    req_a[k*W +: W] = a;
    req_b[k*W +: W] = b;
    req_c[k*W +: W] = c;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    tick();
    rst = 1'b0;
  endtask

  // One isolated request; checks grant, operand capture, exact latency and hold.
  task automatic run_one(input string tag, input logic [N-1:0] vmask, input logic [N-1:0] exp_rdy,
                         input int k, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] c, input logic [W-1:0] exp_q);
    set_ops(k, a, b, c);
    req_valid = vmask;
    #1;
    chk({tag, "_ready"}, 64'(req_ready), 64'(exp_rdy));
    tick();
    req_valid = '0;
    chk({tag, "_add_a"}, 64'(add_a), 64'(a));
    chk({tag, "_add_c"}, 64'(add_c), 64'(c));
    chk({tag, "_inflight1"}, 64'(inflight), 64'd1);
    repeat (6) tick();
    chk({tag, "_early"}, 64'(rsp_valid), 64'd0);
    tick();
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd1);
    chk({tag, "_rsp_id"}, 64'(rsp_id), 64'(k));
    chk({tag, "_rsp_q"}, 64'(rsp_q), 64'(exp_q));
    chk({tag, "_inflight0"}, 64'(inflight), 64'd0);
    tick();
    chk({tag, "_strobe_1cyc"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_q_hold"}, 64'(rsp_q), 64'(exp_q));
    chk({tag, "_id_hold"}, 64'(rsp_id), 64'(k));
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    req_c = '0;
    @(negedge clk);
    req_valid = 4'b1111;
    #1;
    chk("rst_ready_low", 64'(req_ready), 64'd0);
    tick();
    tick();
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_inflight", 64'(inflight), 64'd0);
    chk("rst_add_a", 64'(add_a), 64'd0);
    chk("rst_rsp_q", 64'(rsp_q), 64'd0);
    req_valid = '0;
    rst = 1'b0;
    tick();

    // Single request from requester 2.
    run_one("single", 4'b0100, 4'b0100, 2, 32'd1, 32'd2, 32'd3, 32'd6);

    // Idle: nothing granted, operands and pointer hold.
    repeat (3) begin
      #1;
      chk("idle_ready", 64'(req_ready), 64'd0);
      tick();
      chk("idle_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("idle_add_a_hold", 64'(add_a), 64'd1);
    end
    req_valid = 4'b1111;
    #1;
    chk("idle_ptr_hold", 64'(req_ready), 64'b1000);
    req_valid = '0;

    // Carry out discarded; pointer at 3 wraps to find requester 1.
    run_one("wrap", 4'b0010, 4'b0010, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
            32'hFFFF_FFFD);

    // Back-to-back round robin from reset.
    do_reset();
    clear_rsp();
    pk = 0;
    for (int k = 0; k < N; k++) set_ops(k, 32'(k), 32'h10, 32'h100);
    req_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("rr_grant%0d", i), 64'(req_ready), 64'(4'b0001 << (i % 4)));
      tick();
    end
    req_valid = '0;
    repeat (12) tick();
    chk("rr_rsp_count", 64'(rid_q.size()), 64'd8);
    if (rid_q.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        chk($sformatf("rr_id%0d", i), 64'(rid_q[i]), 64'(i % 4));
        chk($sformatf("rr_q%0d", i), 64'(rq_q[i]), 64'(32'h110 + (i % 4)));
      end
      chk("rr_consecutive", 64'(rcyc_q[7] - rcyc_q[0]), 64'd7);
    end
    chk("rr_inflight_peak", 64'(pk), 64'd7);
    chk("rr_inflight_end", 64'(inflight), 64'd0);

    // Fairness: requester 3 joins at cycle 2 while requester 0 stays valid.
    do_reset();
    req_valid = 4'b0001;
    #1; chk("fair_c0", 64'(req_ready), 64'b0001);
    tick();
    #1; chk("fair_c1", 64'(req_ready), 64'b0001);
    tick();
    req_valid = 4'b1001;
    #1; chk("fair_c2", 64'(req_ready), 64'b1000);
    tick();
    #1; chk("fair_ptr_to0", 64'(req_ready), 64'b0001);
    req_valid = '0;
    repeat (10) tick();
    clear_rsp();

    // Reset while three operations are in flight.
    req_valid = 4'b0111;
    repeat (3) tick();
    chk("mid_inflight3", 64'(inflight), 64'd3);
    rst = 1'b1;
    req_valid = 4'b1111;
    #1;
    chk("mid_rst_ready", 64'(req_ready), 64'd0);
    tick();
    rst = 1'b0;
    req_valid = '0;
    chk("mid_inflight0", 64'(inflight), 64'd0);
    chk("mid_add_a0", 64'(add_a), 64'd0);
    repeat (10) tick();
    chk("mid_no_rsp", 64'(rid_q.size()), 64'd0);
    chk("mid_inflight_stay0", 64'(inflight), 64'd0);
    run_one("post_rst", 4'b0110, 4'b0010, 1, 32'd5, 32'd6, 32'd7, 32'd18);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
